// File: rtl/opl3_write_sched.sv
// OPL3 CPU-bus write scheduler: two requesters, round-robin into a shared FIFO,
// drained as address/data strobe pairs with guaranteed low gaps. Optional shadow RAM: OPL3_WSCHED_SHADOW_EN.
module opl3_write_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int STROBE_LEN = 2,
    parameter int GAP_CYCLES = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [8:0]                   a_reg,
    input  logic [7:0]                   a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [8:0]                   b_reg,
    input  logic [7:0]                   b_data,
    output logic [1:0]                   opl_addr,
    output logic [7:0]                   opl_dout,
    output logic                         opl_we,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef OPL3_WSCHED_SHADOW_EN
    ,
    input  logic [8:0]                   shadow_raddr,
    output logic [7:0]                   shadow_rdata
`endif
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int PH_MAX = (STROBE_LEN > GAP_CYCLES) ? STROBE_LEN : GAP_CYCLES;
    localparam int PW     = $clog2(PH_MAX) + 1;
    localparam logic [PW-1:0] C_STROBE = PW'(STROBE_LEN - 1);
    localparam logic [PW-1:0] C_GAP    = PW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2
    } state_t;

    logic [16:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_rr;
    logic          w_full;
    logic          w_empty;
    logic          w_a_acc;
    logic          w_b_acc;
    logic          w_push;
    logic          w_pop;
    logic [16:0]   w_wdata;
    logic [16:0]   w_head;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_ph;
    logic [PW-1:0] w_ph_nxt;
    logic          w_last;
    logic [8:0]    r_reg;
    logic [7:0]    r_data;

    // Arbitration: r_rr=0 favours A, r_rr=1 favours B; a lone requester always wins.
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign a_ready = ~w_full & (~r_rr | ~b_valid);
    assign b_ready = ~w_full & (r_rr | ~a_valid);
    assign w_a_acc = a_valid & a_ready;
    assign w_b_acc = b_valid & b_ready;
    assign w_push  = w_a_acc | w_b_acc;
    assign w_wdata = w_a_acc ? {a_reg, a_data} : {b_reg, b_data};
    assign w_head  = r_mem[r_rptr];
    assign fifo_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_rr    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
                r_rr   <= w_a_acc;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

    assign w_last = (r_ph == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: if (w_last) w_state_nxt = S_GAP1;
            S_GAP1: if (w_last) w_state_nxt = S_DATA;
            S_DATA: if (w_last) w_state_nxt = S_GAP2;
            S_GAP2: begin
                if (w_last) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter reloads on every state change and counts down to zero.
    always_comb begin
        w_ph_nxt = r_ph;
        if (w_state_nxt != r_state) begin
            if (w_state_nxt == S_ADDR || w_state_nxt == S_DATA) begin
                w_ph_nxt = C_STROBE;
            end else begin
                w_ph_nxt = C_GAP;
            end
        end else if (!w_last) begin
            w_ph_nxt = r_ph - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            {r_reg, r_data} <= w_head;
        end
    end

    // Output stage: one register after the state so every pin is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            opl_we   <= 1'b0;
            opl_addr <= 2'b00;
            opl_dout <= 8'h00;
            busy     <= 1'b0;
        end else begin
            busy <= (r_state != S_IDLE) | ~w_empty;
            case (r_state)
                S_ADDR, S_GAP1: begin
                    opl_we   <= (r_state == S_ADDR);
                    opl_addr <= {r_reg[8], 1'b0};
                    opl_dout <= r_reg[7:0];
                end
                S_DATA, S_GAP2: begin
                    opl_we   <= (r_state == S_DATA);
                    opl_addr <= {r_reg[8], 1'b1};
                    opl_dout <= r_data;
                end
                default: begin
                    opl_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPL3_WSCHED_SHADOW_EN
    logic [7:0] r_shadow [512];

    always_ff @(posedge clk) begin
        if (!reset && w_state_nxt == S_DATA && r_state != S_DATA) begin
            r_shadow[r_reg] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_rdata <= 8'h00;
        end else begin
            shadow_rdata <= r_shadow[shadow_raddr];
        end
    end
`endif

endmodule

// File: tb/tb_opl3_write_sched.sv
// Scoreboard bench for opl3_write_sched (STROBE_LEN=2, GAP_CYCLES=4, FIFO_DEPTH=16):
// stimulus queues expected writes and timed probes; one negedge monitor checks them.
module tb_opl3_write_sched;

    localparam int D = 16;
    localparam int S = 2;
    localparam int G = 4;

    localparam int K_WE     = 0;
    localparam int K_ADDR   = 1;
    localparam int K_DOUT   = 2;
    localparam int K_BUSY   = 3;
    localparam int K_LEVEL  = 4;
    localparam int K_ARDY   = 5;
    localparam int K_BRDY   = 6;
    localparam int K_CNT    = 7;
    localparam int K_QEMPTY = 8;
    localparam int K_TMO    = 9;
    localparam int K_SHD    = 10;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] dout;
        logic [8:0] rg;
    } wr_t;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } probe_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [8:0] a_reg = '0;
    logic [7:0] a_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [8:0] b_reg = '0;
    logic [7:0] b_data = '0;
    logic [1:0] opl_addr;
    logic [7:0] opl_dout;
    logic       opl_we;
    logic       busy;
    logic [4:0] fifo_level;
`ifdef OPL3_WSCHED_SHADOW_EN
    logic [8:0] shadow_raddr = '0;
    logic [7:0] shadow_rdata;
`endif

    wr_t    exp_q[$];
    probe_t probe_q[$];
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     wr_cnt = 0;
    int     hi_cnt = 0;
    int     low_cnt = 1000;
    logic   prev_we = 1'b0;
    logic [8:0] model_idx = '0;
    int     base;
    int     snap;

    opl3_write_sched #(
        .FIFO_DEPTH(D),
        .STROBE_LEN(S),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_reg(a_reg),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_reg(b_reg),
        .b_data(b_data),
        .opl_addr(opl_addr),
        .opl_dout(opl_dout),
        .opl_we(opl_we),
        .busy(busy),
        .fifo_level(fifo_level)
`ifdef OPL3_WSCHED_SHADOW_EN
        ,
        .shadow_raddr(shadow_raddr),
        .shadow_rdata(shadow_rdata)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_WE:     return "opl_we";
            K_ADDR:   return "opl_addr";
            K_DOUT:   return "opl_dout";
            K_BUSY:   return "busy";
            K_LEVEL:  return "fifo_level";
            K_ARDY:   return "a_ready";
            K_BRDY:   return "b_ready";
            K_CNT:    return "write_count";
            K_QEMPTY: return "pending_writes";
            K_TMO:    return "accept_timeout";
            default:  return "shadow_rdata";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: OPL3 bus model (rising-edge write detect) plus timed probe checker.
    always @(negedge clk) begin
        wr_t    w;
        probe_t p;
        int     act;
        if (opl_we && !prev_we) begin
            wr_cnt++;
            chk("strobe_gap", (low_cnt >= G) ? 1 : 0, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {22'd0, opl_addr, opl_dout}, 0);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", int'(opl_addr), int'(w.addr));
                chk("wr_dout", int'(opl_dout), int'(w.dout));
                if (opl_addr[0]) chk("wr_index", int'(model_idx), int'(w.rg));
            end
            if (!opl_addr[0]) model_idx = {opl_addr[1], opl_dout};
            hi_cnt = 1;
        end else if (opl_we) begin
            hi_cnt++;
        end else if (prev_we) begin
            chk("strobe_len", hi_cnt, S);
            low_cnt = 1;
        end else begin
            low_cnt++;
        end
        prev_we = opl_we;

        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            case (p.kind)
                K_WE:     act = int'(opl_we);
                K_ADDR:   act = int'(opl_addr);
                K_DOUT:   act = int'(opl_dout);
                K_BUSY:   act = int'(busy);
                K_LEVEL:  act = int'(fifo_level);
                K_ARDY:   act = int'(a_ready);
                K_BRDY:   act = int'(b_ready);
                K_CNT:    act = wr_cnt;
                K_QEMPTY: act = exp_q.size();
                K_TMO:    act = p.val;
`ifdef OPL3_WSCHED_SHADOW_EN
                K_SHD:    act = int'(shadow_rdata);
`endif
                default:  act = -1;
            endcase
            chk(kname(p.kind), act, (p.kind == K_TMO) ? 0 : p.val);
        end
    end

    task automatic probe(input int c, input int k, input int v);
        probe_t p;
        p.cyc  = c;
        p.kind = k;
        p.val  = v;
        probe_q.push_back(p);
    endtask

    task automatic expect_entry(input logic [8:0] rg, input logic [7:0] d);
        wr_t w;
        w.addr = {rg[8], 1'b0};
        w.dout = rg[7:0];
        w.rg   = rg;
        exp_q.push_back(w);
        w.addr = {rg[8], 1'b1};
        w.dout = d;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; first handshake can occur at the following edge.
    task automatic stream(input int na, input int nb,
                          input logic [8:0] ar, input logic [7:0] ad,
                          input logic [8:0] br, input logic [7:0] bd);
        int   ia = 0;
        int   ib = 0;
        int   g = 0;
        logic acc_a;
        logic acc_b;
        while ((ia < na || ib < nb) && g < 200) begin
            a_valid = (ia < na);
            a_reg   = ar + 9'(ia);
            a_data  = ad + 8'(ia);
            b_valid = (ib < nb);
            b_reg   = br + 9'(ib);
            b_data  = bd + 8'(ib);
            #1;
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            @(posedge clk);
            if (acc_a) ia++;
            if (acc_b) ib++;
            @(negedge clk);
            g++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (g >= 200) probe(cyc + 1, K_TMO, (na - ia) + (nb - ib));
    endtask

    initial begin
        do_reset();

        // Reset state
        probe(cyc + 1, K_WE, 0);
        probe(cyc + 1, K_ADDR, 0);
        probe(cyc + 1, K_DOUT, 0);
        probe(cyc + 1, K_BUSY, 0);
        probe(cyc + 1, K_LEVEL, 0);
        probe(cyc + 1, K_ARDY, 1);
        probe(cyc + 1, K_BRDY, 1);
`ifdef OPL3_WSCHED_SHADOW_EN
        probe(cyc + 1, K_SHD, 0);
`endif
        wait_cyc(cyc + 2);

        // Single write 0x105 = 0x01, cycle-exact strobe table
        base = cyc + 1;
        expect_entry(9'h105, 8'h01);
        probe(base, K_LEVEL, 1);
        for (int n = 1; n <= 15; n++) begin
            probe(base + n, K_WE, (n == 2 || n == 3 || n == 8 || n == 9) ? 1 : 0);
            probe(base + n, K_ADDR, (n == 1) ? 0 : (n <= 7) ? 2 : 3);
            probe(base + n, K_DOUT, (n == 1) ? 0 : (n <= 7) ? 8'h05 : 8'h01);
            probe(base + n, K_BUSY, (n <= 13) ? 1 : 0);
        end
        probe(base + 1, K_LEVEL, 0);
        stream(1, 0, 9'h105, 8'h01, 9'h000, 8'h00);
        wait_cyc(base + 17);

        // A and B streaming together: A0,B0,A1,B1,... each 12 cycles apart
        do_reset();
        base = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            expect_entry(9'h020 + 9'(i), 8'h10 + 8'(i));
            expect_entry(9'h140 + 9'(i), 8'h80 + 8'(i));
        end
        for (int k = 0; k < 8; k++) begin
            probe(base + 12 * k + 1, K_WE, 0);
            probe(base + 12 * k + 2, K_WE, 1);
            probe(base + 12 * k + 2, K_ADDR, (k % 2 == 1) ? 2 : 0);
        end
        stream(4, 4, 9'h020, 8'h10, 9'h140, 8'h80);
        wait_cyc(base + 12 * 8 + 4);

        // Fill: FIFO reaches 16, a_ready drops, held entry accepted right after a pop
        do_reset();
        base = cyc + 1;
        for (int i = 0; i < 19; i++) expect_entry(9'h040 + 9'(i), 8'h00 + 8'(i));
        probe(base + 16, K_LEVEL, 15);
        probe(base + 17, K_LEVEL, 16);
        probe(base + 17, K_ARDY, 0);
        probe(base + 24, K_LEVEL, 16);
        probe(base + 24, K_ARDY, 0);
        probe(base + 25, K_LEVEL, 15);
        probe(base + 25, K_ARDY, 1);
        probe(base + 26, K_LEVEL, 16);
        stream(19, 0, 9'h040, 8'h00, 9'h000, 8'h00);
        wait_cyc(base + 19 * 12 + 4);

        // Reset during the second data-strobe cycle with 3 entries queued
        do_reset();
        base = cyc + 1;
        expect_entry(9'h0B0, 8'h20);
        probe(base + 8, K_WE, 1);
        probe(base + 8, K_ADDR, 1);
        probe(base + 8, K_DOUT, 8'h20);
        probe(base + 9, K_WE, 1);
        probe(base + 9, K_LEVEL, 3);
        probe(base + 10, K_WE, 0);
        probe(base + 10, K_LEVEL, 0);
        probe(base + 10, K_BUSY, 0);
        probe(base + 60, K_BUSY, 0);
        probe(base + 110, K_WE, 0);
        probe(base + 110, K_BUSY, 0);
        stream(4, 0, 9'h0B0, 8'h20, 9'h000, 8'h00);
        wait_cyc(base + 9);
        reset = 1'b1;
        wait_cyc(base + 10);
        reset = 1'b0;
        wait_cyc(base + 112);

        // Edge visibility: 5 back-to-back B entries give exactly 10 recognized writes
        do_reset();
        base = cyc + 1;
        snap = wr_cnt;
        for (int i = 0; i < 5; i++) expect_entry(9'h1A0 + 9'(i), 8'h55 + 8'(i));
        probe(base + 70, K_CNT, snap + 10);
        stream(0, 5, 9'h000, 8'h00, 9'h1A0, 8'h55);
        wait_cyc(base + 72);

`ifdef OPL3_WSCHED_SHADOW_EN
        do_reset();
        base = cyc + 1;
        expect_entry(9'h0A0, 8'h44);
        probe(base + 21, K_SHD, 8'h44);
        stream(1, 0, 9'h0A0, 8'h44, 9'h000, 8'h00);
        wait_cyc(base + 20);
        shadow_raddr = 9'h0A0;
        wait_cyc(base + 23);
`endif

        probe(cyc + 1, K_QEMPTY, 0);
        wait_cyc(cyc + 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
